// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified I/D syncram port arbiter:
//   - FSM state encoding (3-bit: IDLE=0, ISSUE_I=1, ISSUE_D=2, RESP_I=3, RESP_D=4)
//   - requester identifiers (REQ_I=0, REQ_D=1)
//   - helper that maps the fixed-priority parameter onto a requester id
// No ports; imported by mem_arb_pick and mem_port_arbiter.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Requester that wins a tie under fixed priority.
    function automatic logic fixed_pref(input logic d_prio);
        logic pref;
        if (d_prio) begin
            pref = REQ_D;
        end else begin
            pref = REQ_I;
        end
        return pref;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select between the fetch (I) and load/store (D)
// requesters.  A lone requester always wins; a tie is resolved either by the
// fixed D_PRIO preference or, when RR_EN is set, by the round-robin pointer.
// Ports:
//   i_req, d_req  in   request lines sampled by the arbiter in IDLE
//   rr_ptr        in   preferred requester for the next tie (RR mode only)
//   valid         out  at least one request present
//   win           out  winning requester id (REQ_I / REQ_D), 0 when !valid
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter bit D_PRIO = 1'b1,
    parameter bit RR_EN  = 1'b0
) (
    input  logic i_req,
    input  logic d_req,
    input  logic rr_ptr,
    output logic valid,
    output logic win
);

    logic tie_pref_s;

    // Tie preference: round-robin pointer or the fixed priority.
    always_comb begin
        tie_pref_s = REQ_I;
        if (RR_EN) begin
            tie_pref_s = rr_ptr;
        end else begin
            tie_pref_s = fixed_pref(D_PRIO);
        end
    end

    // Winner select.
    always_comb begin
        valid = 1'b0;
        win   = REQ_I;
        case ({d_req, i_req})
            2'b01: begin
                valid = 1'b1;
                win   = REQ_I;
            end
            2'b10: begin
                valid = 1'b1;
                win   = REQ_D;
            end
            2'b11: begin
                valid = 1'b1;
                win   = tie_pref_s;
            end
            default: begin
                valid = 1'b0;
                win   = REQ_I;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one syncram port between the CPU fetch port (I) and the load/store
// port (D).  One transaction is in flight at a time:
//   IDLE -> ISSUE_x (gnt, mem command) -> RESP_x (rvalid, reads only) -> IDLE
// Optional feature: define MEM_ARB_RR_EN to resolve ties round-robin
// (1-bit pointer, I preferred first after reset).  Without it ties follow
// D_PRIO and no pointer register exists.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   i_req/i_addr                       fetch request (read only)
//   i_gnt/i_rvalid/i_rdata             fetch grant pulse, data valid pulse, data
//   d_req/d_wr/d_addr/d_wdata          load/store request
//   d_gnt/d_rvalid/d_rdata             data grant pulse, read valid pulse, data
//   mem_cs/mem_we/mem_addr/mem_din     syncram command
//   mem_dout                           syncram read data (one cycle after read)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int D_PRIO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    arb_state_t        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wr_r;
    logic              i_gnt_r;
    logic              d_gnt_r;
    logic              i_rvalid_r;
    logic              d_rvalid_r;
    logic              mem_cs_r;
    logic              mem_we_r;

    logic              pick_valid_s;
    logic              pick_win_s;
    logic              rr_ptr_s;
    logic              i_rvalid_s;
    logic              d_rvalid_s;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;

    logic rr_ptr_r;

    // Round-robin pointer: the loser of each arbitration is preferred next.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= REQ_I;
        end else if ((state_r == IDLE) && pick_valid_s) begin
            rr_ptr_r <= ~pick_win_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign rr_ptr_s = rr_ptr_r;
`else
    localparam bit RR_EN = 1'b0;

    assign rr_ptr_s = REQ_I;
`endif

    mem_arb_pick #(
        .D_PRIO (D_PRIO != 0),
        .RR_EN  (RR_EN)
    ) u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .rr_ptr (rr_ptr_s),
        .valid  (pick_valid_s),
        .win    (pick_win_s)
    );

    // Arbiter FSM with capture registers and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wr_r       <= 1'b0;
            i_gnt_r    <= 1'b0;
            d_gnt_r    <= 1'b0;
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            mem_cs_r   <= 1'b0;
            mem_we_r   <= 1'b0;
        end else begin
            // Strobes are single-cycle; each state raises only its own.
            i_gnt_r    <= 1'b0;
            d_gnt_r    <= 1'b0;
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            mem_cs_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        mem_cs_r <= 1'b1;
                        if (pick_win_s == REQ_D) begin
                            addr_r   <= d_addr;
                            wdata_r  <= d_wdata;
                            wr_r     <= d_wr;
                            mem_we_r <= d_wr;
                            d_gnt_r  <= 1'b1;
                            state_r  <= ISSUE_D;
                        end else begin
                            // Fetch never writes; write data keeps its last value.
                            addr_r   <= i_addr;
                            wr_r     <= 1'b0;
                            i_gnt_r  <= 1'b1;
                            state_r  <= ISSUE_I;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE_I: begin
                    i_rvalid_r <= 1'b1;
                    state_r    <= RESP_I;
                end
                ISSUE_D: begin
                    // A write completes at grant; only reads need a response cycle.
                    if (wr_r) begin
                        state_r <= IDLE;
                    end else begin
                        d_rvalid_r <= 1'b1;
                        state_r    <= RESP_D;
                    end
                end
                RESP_I: begin
                    state_r <= IDLE;
                end
                RESP_D: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Reset during a response cycle suppresses that response immediately.
    assign i_rvalid_s = i_rvalid_r & ~reset;
    assign d_rvalid_s = d_rvalid_r & ~reset;

    // Read data passes straight from the syncram during the response cycle.
    always_comb begin
        i_rdata = {DATA_W{1'b0}};
        d_rdata = {DATA_W{1'b0}};
        if (i_rvalid_s) begin
            i_rdata = mem_dout;
        end else begin
            i_rdata = {DATA_W{1'b0}};
        end
        if (d_rvalid_s) begin
            d_rdata = mem_dout;
        end else begin
            d_rdata = {DATA_W{1'b0}};
        end
    end

    assign i_gnt    = i_gnt_r;
    assign d_gnt    = d_gnt_r;
    assign i_rvalid = i_rvalid_s;
    assign d_rvalid = d_rvalid_s;
    assign mem_cs   = mem_cs_r;
    assign mem_we   = mem_we_r;
    assign mem_addr = addr_r;
    assign mem_din  = wdata_r;

endmodule
